// File: rtl/pong_button_conditioner.sv
// Push-button front end for the Pong core: synchronise, debounce, detect presses and
// hold a per-frame snapshot so the once-per-frame game logic never misses a short press.
module pong_button_conditioner #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               frame_tick,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_frame,
    output logic               move_up,
    output logic               move_down
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;
    logic               move_up_q;
    logic               move_up_d;
    logic               move_down_q;
    logic               move_down_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             level_q;
            logic             level_d;
            logic             level_dly_q;
            logic             press_q;
            logic             press_d;
            logic             pending_q;
            logic             pending_d;
            logic             frame_q;
            logic             frame_d;

            // Any cycle where the synchronised input agrees with the level restarts the count.
            always_comb begin
                cnt_d   = '0;
                level_d = level_q;
                if (sync2_q[gi] != level_q) begin
                    if (cnt_q == CNT_LAST) begin
                        level_d = sync2_q[gi];
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            assign press_d = level_q & ~level_dly_q;

            // A tick in the same cycle as a press consumes it directly, so pending must end clear.
            always_comb begin
                pending_d = pending_q;
                frame_d   = frame_q;
                if (frame_tick) begin
                    pending_d = 1'b0;
                    frame_d   = level_q | pending_q | press_q;
                end else if (press_q) begin
                    pending_d = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q       <= '0;
                    level_q     <= 1'b0;
                    level_dly_q <= 1'b0;
                    press_q     <= 1'b0;
                    pending_q   <= 1'b0;
                    frame_q     <= 1'b0;
                end else begin
                    cnt_q       <= cnt_d;
                    level_q     <= level_d;
                    level_dly_q <= level_q;
                    press_q     <= press_d;
                    pending_q   <= pending_d;
                    frame_q     <= frame_d;
                end
            end

            assign btn_level[gi] = level_q;
            assign btn_press[gi] = press_q;
            assign btn_frame[gi] = frame_q;
        end
    endgenerate

    assign move_up_d   = btn_frame[0] & ~btn_frame[1];
    assign move_down_d = btn_frame[1] & ~btn_frame[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_up_q   <= 1'b0;
            move_down_q <= 1'b0;
        end else begin
            move_up_q   <= move_up_d;
            move_down_q <= move_down_d;
        end
    end

    assign move_up   = move_up_q;
    assign move_down = move_down_q;

endmodule
